deser_word_aligner: RTL and testbench
=====================================

Name: deser_word_aligner

Overview:
- Sits directly downstream of the serial-to-parallel deserializer in the calorimeter-crystal stand SoC.
- Consumes raw parallel words while the front end transmits a fixed training pattern.
- Issues one-cycle bitslip pulses back to the deserializer until the word boundary matches the pattern, then declares lock and forwards payload words.
- Reports failure if no bit rotation matches.

Parameters:
- DATA_W, 8: parallel word width; also the number of candidate bit rotations.
- TRAIN_PATTERN, 8'hF0: training word expected when aligned (width DATA_W).
- LOCK_COUNT, 16: consecutive valid matching words required for lock (>=1).
- SLIP_WAIT, 4: clocks to ignore input after each bitslip, covering deserializer settling (>=1).
- SLIP_W, $clog2(DATA_W)+1: width of slip_cnt.

Ports:
- clk, in, 1: system clock; all logic is rising-edge.
- reset_n, in, 1: asynchronous active-low reset.
- align_start, in, 1: single-cycle request to (re)start alignment.
- din, in, DATA_W: parallel word from the deserializer.
- din_valid, in, 1: din qualifier.
- bitslip, out, 1: one-cycle pulse to the deserializer requesting a 1-bit rotation.
- dout, out, DATA_W: aligned payload word.
- dout_valid, out, 1: dout qualifier.
- locked, out, 1: alignment achieved.
- align_err, out, 1: all rotations tried without lock.
- slip_cnt, out, SLIP_W: bitslips issued in the current attempt.

Behaviour:
- All outputs are registered. Reset values: bitslip=0, dout=0, dout_valid=0, locked=0, align_err=0, slip_cnt=0. FSM resets to IDLE.
- Asserting reset_n low at any time, including mid-wait or while locked, returns everything to reset values asynchronously.
- FSM states: IDLE, CHECK, WAIT, LOCKED, FAIL.
- align_start has top priority in every state, including the same cycle as a match or mismatch:
  - Next state is CHECK.
  - slip_cnt, match counter and wait counter are cleared; locked=0, align_err=0, dout_valid=0, bitslip=0.
- IDLE: waits for align_start. din is ignored.
- CHECK: on a cycle with din_valid=1:
  - Match (din==TRAIN_PATTERN): increment the match counter.
    - If the new count equals LOCK_COUNT, go to LOCKED with locked=1 on the next edge.
  - Mismatch: clear the match counter.
    - If slip_cnt < DATA_W-1, go to WAIT, with bitslip=1 for exactly one cycle and slip_cnt+1, both on the same edge.
    - Otherwise go to FAIL with align_err=1 on the next edge. No bitslip is issued.
  - Cycles with din_valid=0 leave the counters unchanged; gaps do not break the consecutive-match run.
- WAIT:
  - Counts SLIP_WAIT clocks regardless of din_valid, then returns to CHECK.
  - Words arriving during WAIT are discarded.
  - bitslip stays 0 after its single pulse.
- LOCKED:
  - dout <= din and dout_valid <= din_valid every cycle, giving 1-cycle latency.
  - locked stays 1. No pattern checking; payload content never drops lock.
  - Leaves only on align_start or reset.
- FAIL: align_err stays 1, locked=0, dout_valid=0, until align_start or reset.
- slip_cnt holds its final value in LOCKED and FAIL.
- slip_cnt never exceeds DATA_W-1, so at most DATA_W-1 bitslips are issued per attempt.
- Exactly one of {locked, align_err} or neither is high; never both.

Test Plan:
- Bench uses a deserializer model that rotates the word by 1 bit per bitslip pulse.
- Aligned at start: model offset 0, align_start pulse, continuous 8'hF0 -> bitslip never asserted; locked=1 after the 16th valid match; slip_cnt=0.
- Offset 3: align_start -> exactly 3 bitslip pulses, each followed by >=4 ignored cycles; then locked=1; slip_cnt=3.
- Din_valid toggling every other cycle at offset 0: lock after 16 valid matches (~32 clocks); dout_valid=0 throughout alignment.
- Pattern never present (constant 8'h00): 7 bitslip pulses, then align_err=1, locked=0, slip_cnt=7.
  - A further align_start clears align_err and slip_cnt to 0 on the next edge.
- Locked, then payload 8'h12, 8'h34 with din_valid=1 -> dout=8'h12 then 8'h34, each one cycle after input; locked stays 1.
- Reset_n low mid-WAIT at slip_cnt=2 -> all outputs 0 immediately.
  - After release, FSM stays IDLE and ignores din until align_start.
- Align_start asserted in the same cycle as the 16th match -> locked stays 0 and the match counter restarts from 0.

Source files
------------

// File: rtl/deser_word_aligner.sv
// Word aligner behind a serial-to-parallel deserializer: slips the bit boundary one
// position at a time until the training pattern is seen, then forwards payload words.
module deser_word_aligner #(
  parameter int                 DATA_W        = 8,
  parameter logic [DATA_W-1:0]  TRAIN_PATTERN = 8'hF0,
  parameter int                 LOCK_COUNT    = 16,
  parameter int                 SLIP_WAIT     = 4,
  parameter int                 SLIP_W        = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              align_start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              bitslip,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              locked,
  output logic              align_err,
  output logic [SLIP_W-1:0] slip_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int WC_W = $clog2(SLIP_WAIT + 1);

  localparam logic [MC_W-1:0]   MATCH_LAST = MC_W'(LOCK_COUNT);
  localparam logic [WC_W-1:0]   WAIT_LAST  = WC_W'(SLIP_WAIT - 1);
  // The last rotation is the one that reaches DATA_W-1 slips; a mismatch there is final.
  localparam logic [SLIP_W-1:0] SLIP_MAX   = SLIP_W'(DATA_W - 1);

  logic [2:0]      state;
  logic [MC_W-1:0] match_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic [MC_W-1:0] match_next;

  assign match_next = match_cnt + MC_W'(1);

  // NOTE: every register here is written with <= so all of them update from the
  // same pre-edge values; blocking assignments would make the result order-dependent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      wait_cnt   <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      bitslip <= 1'b0;

      if (align_start) begin
        // A restart overrides whatever the current state would have done this cycle.
        state      <= ST_CHECK;
        match_cnt  <= '0;
        wait_cnt   <= '0;
        slip_cnt   <= '0;
        dout_valid <= 1'b0;
        locked     <= 1'b0;
        align_err  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
          end

          ST_CHECK: begin
            if (din_valid) begin
              if (din == TRAIN_PATTERN) begin
                match_cnt <= match_next;
                if (match_next == MATCH_LAST) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                if (slip_cnt < SLIP_MAX) begin
                  state    <= ST_WAIT;
                  wait_cnt <= '0;
                  bitslip  <= 1'b1;
                  slip_cnt <= slip_cnt + SLIP_W'(1);
                end else begin
                  state     <= ST_FAIL;
                  align_err <= 1'b1;
                end
              end
            end
          end

          ST_WAIT: begin
            // Words are unreliable while the deserializer settles after a slip.
            if (wait_cnt == WAIT_LAST) begin
              state <= ST_CHECK;
            end else begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
          end

          ST_LOCKED: begin
            dout       <= din;
            dout_valid <= din_valid;
          end

          ST_FAIL: begin
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deser_word_aligner.sv
// Bench for deser_word_aligner: a rotating deserializer model drives the DUT and a
// behavioural model of the alignment rules predicts every output cycle by cycle.
module tb_deser_word_aligner;

  localparam int          DATA_W     = 8;
  localparam logic [7:0]  PAT        = 8'hF0;
  localparam int          LOCK_COUNT = 16;
  localparam int          SLIP_WAIT  = 4;
  localparam int          SLIP_W     = $clog2(DATA_W) + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              align_start;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              bitslip;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              locked;
  logic              align_err;
  logic [SLIP_W-1:0] slip_cnt;

  deser_word_aligner #(
    .DATA_W(DATA_W), .TRAIN_PATTERN(PAT), .LOCK_COUNT(LOCK_COUNT),
    .SLIP_WAIT(SLIP_WAIT), .SLIP_W(SLIP_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .align_start(align_start), .din(din),
    .din_valid(din_valid), .bitslip(bitslip), .dout(dout), .dout_valid(dout_valid),
    .locked(locked), .align_err(align_err), .slip_cnt(slip_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Alignment rules expressed as a phase plus counters.
  typedef enum {M_IDLE, M_HUNT, M_LOCK, M_FAIL} mphase_t;
  mphase_t    ph;
  int         run, settle, m_slips;
  logic       m_bitslip, m_locked, m_err, m_dvalid;
  logic [7:0] m_dout;

  task automatic model_reset();
    ph = M_IDLE; run = 0; settle = 0; m_slips = 0;
    m_bitslip = 0; m_locked = 0; m_err = 0; m_dvalid = 0; m_dout = '0;
  endtask

  task automatic model_update(input logic st, input logic v, input logic [7:0] d);
    m_bitslip = 1'b0;
    if (st) begin
      ph = M_HUNT; run = 0; settle = 0; m_slips = 0;
      m_locked = 0; m_err = 0; m_dvalid = 0;
    end else begin
      case (ph)
        M_HUNT: begin
          if (settle > 0) settle--;
          else if (v) begin
            if (d == PAT) begin
              run++;
              if (run == LOCK_COUNT) begin ph = M_LOCK; m_locked = 1; end
            end else begin
              run = 0;
              if (m_slips < DATA_W - 1) begin
                m_slips++; m_bitslip = 1; settle = SLIP_WAIT;
              end else begin
                ph = M_FAIL; m_err = 1;
              end
            end
          end
        end
        M_LOCK: begin m_dout = d; m_dvalid = v; end
        default: ;
      endcase
    end
  endtask

  // Deserializer plant: word seen = base rotated left by the remaining offset;
  // each bitslip removes one position and is followed by garbage while settling.
  int         plant_off, garbage, pulses, last_pulse, cyc;
  int         gap_viol, both_viol;
  logic [7:0] plant_base;

  function automatic logic [7:0] rotl(input logic [7:0] w, input int s);
    logic [15:0] t;
    t = {w, w} << s;
    return t[15:8];
  endfunction

  task automatic plant_word(output logic [7:0] w);
    if (garbage > 0) begin
      w = 8'($urandom);
      if (w == PAT) w = w ^ 8'h01;
      garbage--;
    end else begin
      w = rotl(plant_base, plant_off);
    end
  endtask

  task automatic plant_setup(input int off, input logic [7:0] base);
    plant_off = off; plant_base = base; garbage = 0; pulses = 0; last_pulse = -1;
  endtask

  task automatic compare_all();
    check("bitslip",    bitslip,    m_bitslip);
    check("locked",     locked,     m_locked);
    check("align_err",  align_err,  m_err);
    check("slip_cnt",   slip_cnt,   m_slips);
    check("dout_valid", dout_valid, m_dvalid);
    check("dout",       dout,       m_dout);
    if (locked && align_err) both_viol++;
    if (bitslip) begin
      pulses++;
      if (last_pulse >= 0 && cyc - last_pulse < SLIP_WAIT + 1) gap_viol++;
      last_pulse = cyc;
      plant_off  = (plant_off + DATA_W - 1) % DATA_W;
      garbage    = SLIP_WAIT;
    end
    cyc++;
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result.
  task automatic step(input logic st, input logic v, input logic [7:0] d);
    align_start = st; din_valid = v; din = d;
    @(posedge clk);
    model_update(st, v, d);
    @(negedge clk);
    compare_all();
  endtask

  // vpct < 0 selects din_valid toggling every other word, starting high.
  task automatic hunt(input int off, input logic [7:0] base, input int vpct,
                      input int budget, output int used);
    logic       v;
    logic [7:0] w;
    plant_setup(off, base);
    step(1'b1, 1'b0, 8'h00);
    used = 0;
    while (!(locked || align_err) && used < budget) begin
      v = (vpct < 0) ? (used % 2 == 0) : ($urandom_range(99) < vpct);
      plant_word(w);
      step(1'b0, v, w);
      used++;
    end
    check("hunt_timeout", (used < budget), 1'b1);
  endtask

  int         used;
  int         off;
  logic [7:0] w;

  initial begin
    reset_n = 1'b0; align_start = 1'b0; din = '0; din_valid = 1'b0;
    cyc = 0; gap_viol = 0; both_viol = 0;
    model_reset();
    plant_setup(0, PAT);
    repeat (2) @(negedge clk);
    check("rst_locked", locked, 1'b0);
    check("rst_err",    align_err, 1'b0);
    check("rst_slip",   slip_cnt, 0);
    check("rst_dvalid", dout_valid, 1'b0);
    reset_n = 1'b1;

    // Idle ignores din until align_start.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PAT);

    // Already aligned.
    hunt(0, PAT, 100, 100, used);
    check("aligned_pulses", pulses, 0);
    check("aligned_cycles", used, LOCK_COUNT);
    check("aligned_slip",   slip_cnt, 0);

    // Locked payload forwarding.
    step(1'b0, 1'b1, 8'h12);
    check("payload0", dout, 8'h12);
    step(1'b0, 1'b1, 8'h34);
    check("payload1", dout, 8'h34);
    check("payload_locked", locked, 1'b1);

    // Offset 3.
    hunt(3, PAT, 100, 200, used);
    check("off3_pulses", pulses, 3);
    check("off3_cycles", used, 3 * (SLIP_WAIT + 1) + LOCK_COUNT);
    check("off3_slip",   slip_cnt, 3);

    // din_valid toggling at offset 0.
    hunt(0, PAT, -1, 200, used);
    check("toggle_cycles", used, 2 * LOCK_COUNT - 1);

    // Pattern never present.
    hunt(0, 8'h00, 100, 200, used);
    check("fail_pulses", pulses, DATA_W - 1);
    check("fail_cycles", used, (DATA_W - 1) * (SLIP_WAIT + 1) + 1);
    check("fail_err",    align_err, 1'b1);
    check("fail_locked", locked, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check("restart_err",  align_err, 1'b0);
    check("restart_slip", slip_cnt, 0);

    // align_start coinciding with the final match.
    plant_setup(0, PAT);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < LOCK_COUNT - 1; i++) step(1'b0, 1'b1, PAT);
    step(1'b1, 1'b1, PAT);
    check("coinc_locked", locked, 1'b0);
    for (int i = 0; i < LOCK_COUNT - 1; i++) step(1'b0, 1'b1, PAT);
    check("coinc_relock_early", locked, 1'b0);
    step(1'b0, 1'b1, PAT);
    check("coinc_relock", locked, 1'b1);

    // Reset in the middle of WAIT.
    plant_setup(5, PAT);
    step(1'b1, 1'b0, 8'h00);
    used = 0;
    while (pulses < 2 && used < 100) begin
      plant_word(w);
      step(1'b0, 1'b1, w);
      used++;
    end
    check("prerst_pulses", pulses, 2);
    check("prerst_slip",   slip_cnt, 2);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_bitslip", bitslip, 1'b0);
    check("midrst_locked",  locked, 1'b0);
    check("midrst_err",     align_err, 1'b0);
    check("midrst_slip",    slip_cnt, 0);
    check("midrst_dvalid",  dout_valid, 1'b0);
    check("midrst_dout",    dout, 8'h00);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, PAT);
    check("postrst_idle", locked, 1'b0);

    // Randomized attempts with payload afterwards.
    for (int k = 0; k < 6; k++) begin
      off = $urandom_range(DATA_W - 1);
      hunt(off, PAT, $urandom_range(100, 40), 1000, used);
      check("rand_locked", locked, 1'b1);
      check("rand_slip",   slip_cnt, off);
      check("rand_pulses", pulses, off);
      for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(1)), 8'($urandom));
    end

    check("slip_gap",  gap_viol, 0);
    check("both_high", both_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
